avalon_rt_ctrl_multi: RTL and testbench

//  Multi-channel Avalon-MM slave control/status block for the raytracer array.
//  - Issues one-cycle start pulses to NCH raytracer cores.
//  - Tracks busy/done per core and captures each core's end-of-run status byte.
//  - Raises a maskable level IRQ that stays high until the host services it.

---
 rtl/avalon_rt_ctrl_multi.sv | 211 +++++++++++++++++++++
 tb/tb_avalon_rt_ctrl_multi.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_rt_ctrl_multi.sv
// Avalon-MM control/status slave for NCH raytracer cores: start pulses, busy/done tracking, status capture, maskable IRQ.
// Optional per-channel watchdog enabled by defining RT_WDOG_EN (TIMEOUT_CYC sets the limit).
module avalon_rt_ctrl_multi #(
  parameter int NCH         = 4,
  parameter int STAT_W      = 8,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              avs_s0_address,
  input  logic                    avs_s0_write,
  input  logic                    avs_s0_read,
  input  logic [31:0]             avs_s0_writedata,
  output logic [31:0]             avs_s0_readdata,
  output logic                    rdirq,
  output logic [NCH-1:0]          start_rt,
  input  logic [NCH-1:0]          end_rt,
  input  logic [NCH*STAT_W-1:0]   end_rtstat
);

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_PEND   = 4'h2;
  localparam logic [3:0] ADDR_EN     = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ch_state_t;

  ch_state_t         state_r [NCH];
  logic [STAT_W-1:0] stat_r  [NCH];
  logic [NCH-1:0]    pend_r;
  logic [NCH-1:0]    en_r;
  logic [NCH-1:0]    reject_r;
  logic [NCH-1:0]    timeout_r;
  logic [NCH-1:0]    start_r;
  logic [31:0]       readdata_r;
  logic              irq_r;

`ifdef RT_WDOG_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0]  cnt_r [NCH];
`endif

  logic              wr_ctrl_s;
  logic              wr_status_s;
  logic              wr_pend_s;
  logic              wr_en_s;
  logic [NCH-1:0]    ctrl_req_s;
  logic [NCH-1:0]    pend_clr_s;
  logic [NCH-1:0]    rej_clr_s;
  logic [NCH-1:0]    busy_s;
  logic [NCH-1:0]    done_s;
  logic [NCH-1:0]    end_hit_s;
  logic [NCH-1:0]    wdog_hit_s;
  logic [NCH-1:0]    pend_set_s;
  logic [NCH-1:0]    rej_set_s;
  logic [31:0]       rd_mux_s;
  logic              unused_s;

  assign wr_ctrl_s   = avs_s0_write && (avs_s0_address == ADDR_CTRL);
  assign wr_status_s = avs_s0_write && (avs_s0_address == ADDR_STATUS);
  assign wr_pend_s   = avs_s0_write && (avs_s0_address == ADDR_PEND);
  assign wr_en_s     = avs_s0_write && (avs_s0_address == ADDR_EN);
  assign ctrl_req_s  = wr_ctrl_s   ? avs_s0_writedata[NCH-1:0]    : {NCH{1'b0}};
  assign pend_clr_s  = wr_pend_s   ? avs_s0_writedata[NCH-1:0]    : {NCH{1'b0}};
  assign rej_clr_s   = wr_status_s ? avs_s0_writedata[24 +: NCH] : {NCH{1'b0}};
  assign unused_s    = ^avs_s0_writedata;

  // Per-channel event decode; pend/reject sets take priority over same-cycle clears
  always_comb begin
    busy_s     = {NCH{1'b0}};
    done_s     = {NCH{1'b0}};
    end_hit_s  = {NCH{1'b0}};
    wdog_hit_s = {NCH{1'b0}};
    rej_set_s  = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      busy_s[i]    = (state_r[i] == ST_BUSY);
      done_s[i]    = (state_r[i] == ST_DONE);
      end_hit_s[i] = busy_s[i] && end_rt[i];
      rej_set_s[i] = ctrl_req_s[i] && (state_r[i] != ST_IDLE);
`ifdef RT_WDOG_EN
      wdog_hit_s[i] = busy_s[i] && !end_rt[i] && (cnt_r[i] == CNT_LAST);
`else
      wdog_hit_s[i] = 1'b0;
`endif
    end
    pend_set_s = end_hit_s | wdog_hit_s;
  end

  // Channel FSMs with their pend, reject, timeout, status capture and start pulse state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r    <= {NCH{1'b0}};
      reject_r  <= {NCH{1'b0}};
      timeout_r <= {NCH{1'b0}};
      start_r   <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= ST_IDLE;
        stat_r[i]  <= {STAT_W{1'b0}};
`ifdef RT_WDOG_EN
        cnt_r[i]   <= {CNT_W{1'b0}};
`endif
      end
    end else begin
      pend_r   <= (pend_r & ~pend_clr_s) | pend_set_s;
      reject_r <= (reject_r & ~rej_clr_s) | rej_set_s;
      for (int i = 0; i < NCH; i++) begin
        start_r[i] <= 1'b0;
        case (state_r[i])
          ST_IDLE: begin
            if (ctrl_req_s[i]) begin
              state_r[i] <= ST_BUSY;
              start_r[i] <= 1'b1;
`ifdef RT_WDOG_EN
              cnt_r[i]   <= {CNT_W{1'b0}};
`endif
            end else begin
              state_r[i] <= ST_IDLE;
            end
          end
          ST_BUSY: begin
            if (end_hit_s[i]) begin
              state_r[i] <= ST_DONE;
              stat_r[i]  <= end_rtstat[i*STAT_W +: STAT_W];
            end else if (wdog_hit_s[i]) begin
              state_r[i]   <= ST_DONE;
              stat_r[i]    <= {STAT_W{1'b1}};
              timeout_r[i] <= 1'b1;
            end else begin
              state_r[i] <= ST_BUSY;
`ifdef RT_WDOG_EN
              cnt_r[i]   <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
            end
          end
          ST_DONE: begin
            if (pend_clr_s[i]) begin
              state_r[i]   <= ST_IDLE;
              timeout_r[i] <= 1'b0;
            end else begin
              state_r[i] <= ST_DONE;
            end
          end
          default: begin
            state_r[i] <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // IRQ enable register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_r <= {NCH{1'b0}};
    end else if (wr_en_s) begin
      en_r <= avs_s0_writedata[NCH-1:0];
    end else begin
      en_r <= en_r;
    end
  end

  // Read-side register map decode
  always_comb begin
    rd_mux_s = 32'd0;
    case (avs_s0_address)
      ADDR_CTRL: rd_mux_s = 32'd0;
      ADDR_STATUS: begin
        rd_mux_s[0  +: NCH] = busy_s;
        rd_mux_s[8  +: NCH] = done_s;
        rd_mux_s[16 +: NCH] = timeout_r;
        rd_mux_s[24 +: NCH] = reject_r;
      end
      ADDR_PEND: rd_mux_s[NCH-1:0] = pend_r;
      ADDR_EN:   rd_mux_s[NCH-1:0] = en_r;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (avs_s0_address == 4'(8 + i)) begin
            rd_mux_s[STAT_W-1:0] = stat_r[i];
          end else begin
            rd_mux_s = rd_mux_s;
          end
        end
      end
    endcase
  end

  // Registered read data (held between reads) and level IRQ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      irq_r <= |(pend_r & en_r);
      if (avs_s0_read) begin
        readdata_r <= rd_mux_s;
      end else begin
        readdata_r <= readdata_r;
      end
    end
  end

  assign avs_s0_readdata = readdata_r;
  assign rdirq           = irq_r;
  assign start_rt        = start_r;

endmodule

// File: tb/tb_avalon_rt_ctrl_multi.sv
// Self-checking bench for avalon_rt_ctrl_multi: read results are scoreboarded through a queue,
// pulse/IRQ outputs are compared directly. Defining RT_WDOG_EN also exercises the watchdog path.
module tb_avalon_rt_ctrl_multi;

  localparam int NCH    = 4;
  localparam int STAT_W = 8;
  localparam int TMO    = 16;

  logic                  clk;
  logic                  reset_n;
  logic [3:0]            avs_s0_address;
  logic                  avs_s0_write;
  logic                  avs_s0_read;
  logic [31:0]           avs_s0_writedata;
  logic [31:0]           avs_s0_readdata;
  logic                  rdirq;
  logic [NCH-1:0]        start_rt;
  logic [NCH-1:0]        end_rt;
  logic [NCH*STAT_W-1:0] end_rtstat;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_valid;

  avalon_rt_ctrl_multi #(.NCH(NCH), .STAT_W(STAT_W), .TIMEOUT_CYC(TMO)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avs_s0_address   (avs_s0_address),
    .avs_s0_write     (avs_s0_write),
    .avs_s0_read      (avs_s0_read),
    .avs_s0_writedata (avs_s0_writedata),
    .avs_s0_readdata  (avs_s0_readdata),
    .rdirq            (rdirq),
    .start_rt         (start_rt),
    .end_rt           (end_rt),
    .end_rtstat       (end_rtstat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Read results land one cycle after the read strobe
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_valid <= 1'b0;
    else          rd_valid <= avs_s0_read;
  end

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        check_val(tag_q.pop_front(), avs_s0_readdata, exp_q.pop_front());
      end
    end
  end

  // All tasks are entered at a falling edge and return at a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    avs_s0_address   = a;
    avs_s0_writedata = d;
    avs_s0_write     = 1'b1;
    @(negedge clk);
    avs_s0_write     = 1'b0;
    avs_s0_writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    avs_s0_address = a;
    avs_s0_read    = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    avs_s0_read    = 1'b0;
  endtask

  task automatic pulse_end(input int ch, input logic [7:0] st);
    end_rt[ch]                  = 1'b1;
    end_rtstat[ch*STAT_W +: 8]  = st;
    @(negedge clk);
    end_rt     = {NCH{1'b0}};
    end_rtstat = $urandom();
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got 0x00000001 expected 0x00000000");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset_n          = 1'b0;
    avs_s0_address   = 4'h0;
    avs_s0_write     = 1'b0;
    avs_s0_read      = 1'b0;
    avs_s0_writedata = 32'd0;
    end_rt           = {NCH{1'b0}};
    end_rtstat       = $urandom();
    tick(3);
    check_val("rst_start", 32'(start_rt), 32'h0);
    check_val("rst_irq", 32'(rdirq), 32'h0);
    check_val("rst_rdata", avs_s0_readdata, 32'h0);
    reset_n = 1'b1;
    tick(1);

    bus_read(4'h1, 32'h0, "t1_status");
    bus_read(4'h2, 32'h0, "t1_pend");
    bus_read(4'h3, 32'h0, "t1_en");
    check_val("t1_irq", 32'(rdirq), 32'h0);
    check_val("t1_start", 32'(start_rt), 32'h0);

    bus_write(4'h3, 32'h1);
    bus_write(4'h0, 32'h1);
    check_val("t2_start_pulse", 32'(start_rt), 32'h1);
    tick(1);
    check_val("t2_start_one_cycle", 32'(start_rt), 32'h0);
    bus_read(4'h0, 32'h0, "t2_ctrl_rd0");
    bus_read(4'h1, 32'h1, "t2_status_busy");

    bus_write(4'h0, 32'h1);
    check_val("t3_busy_nopulse", 32'(start_rt), 32'h0);
    bus_read(4'h1, 32'h0100_0001, "t3_reject_set");
    bus_write(4'h1, 32'h0100_FFFF);
    bus_read(4'h1, 32'h0000_0001, "t3_reject_w1c");

    pulse_end(1, 8'h33);
    bus_read(4'h9, 32'h0, "idle_end_ignored");
    bus_read(4'h2, 32'h0, "idle_end_nopend");

    pulse_end(0, 8'h5A);
    check_val("t2_irq_latency", 32'(rdirq), 32'h0);
    tick(1);
    check_val("t2_irq_set", 32'(rdirq), 32'h1);
    bus_read(4'h8, 32'h5A, "t2_stat0");
    bus_read(4'h1, 32'h0000_0100, "t2_status_done");
    bus_read(4'h2, 32'h1, "t2_pend");
    tick(3);
    check_val("rd_hold", avs_s0_readdata, 32'h1);

    end_rt[1]         = 1'b1;
    end_rtstat[15:8]  = 8'h77;
    bus_write(4'h0, 32'h2);
    end_rt = {NCH{1'b0}};
    check_val("start_end_same_cycle", 32'(start_rt), 32'h2);
    bus_read(4'h1, 32'h0000_0102, "start_end_status");
    bus_read(4'h9, 32'h0, "start_end_stat1");

    bus_write(4'h3, 32'h3);
    end_rt[1]         = 1'b1;
    end_rtstat[15:8]  = 8'hC3;
    bus_write(4'h2, 32'h1);
    end_rt = {NCH{1'b0}};
    check_val("t4_irq_hold0", 32'(rdirq), 32'h1);
    bus_read(4'h2, 32'h2, "t4_pend");
    check_val("t4_irq_hold1", 32'(rdirq), 32'h1);
    bus_read(4'h1, 32'h0000_0200, "t4_status");
    bus_read(4'h9, 32'hC3, "t4_stat1");
    bus_read(4'h8, 32'h5A, "t4_stat0_kept");

    bus_write(4'h0, 32'h2);
    check_val("done_nopulse", 32'(start_rt), 32'h0);
    bus_read(4'h1, 32'h0200_0200, "done_reject");
    bus_write(4'h1, 32'h0200_0000);
    bus_read(4'h1, 32'h0000_0200, "done_reject_w1c");

    bus_write(4'h3, 32'h0);
    check_val("irq_dis_latency", 32'(rdirq), 32'h1);
    tick(1);
    check_val("irq_disabled", 32'(rdirq), 32'h0);
    bus_write(4'h3, 32'hFF);
    bus_read(4'h3, 32'hF, "en_upper_bits");
    bus_write(4'h2, 32'hFFFF_FFFF);
    bus_read(4'h2, 32'h0, "pend_cleared");
    bus_read(4'h1, 32'h0, "all_idle");
    check_val("irq_after_clear", 32'(rdirq), 32'h0);

    bus_write(4'h4, 32'hFFFF_FFFF);
    bus_read(4'h4, 32'h0, "unmapped_4");
    bus_read(4'hC, 32'h0, "stat_above_nch");
    bus_read(4'hF, 32'h0, "unmapped_f");

    bus_write(4'h0, 32'h5);
    check_val("t5_start", 32'(start_rt), 32'h5);
    pulse_end(0, 8'hA5);
    tick(1);
    check_val("t5_irq_pre", 32'(rdirq), 32'h1);
    bus_read(4'h3, 32'hF, "t5_en_pre");
    reset_n = 1'b0;
    #1;
    check_val("t5_rst_irq", 32'(rdirq), 32'h0);
    check_val("t5_rst_rdata", avs_s0_readdata, 32'h0);
    check_val("t5_rst_start", 32'(start_rt), 32'h0);
    tick(2);
    reset_n = 1'b1;
    pulse_end(2, 8'h99);
    bus_read(4'h1, 32'h0, "t5_status");
    bus_read(4'h2, 32'h0, "t5_pend");
    bus_read(4'hA, 32'h0, "t5_stat2");
    bus_read(4'h8, 32'h0, "t5_stat0");
    bus_read(4'h3, 32'h0, "t5_en");
    check_val("t5_irq", 32'(rdirq), 32'h0);

    bus_write(4'h0, 32'h8);
    check_val("t6_start", 32'(start_rt), 32'h8);
    tick(TMO + 4);
`ifdef RT_WDOG_EN
    bus_read(4'h1, 32'h0008_0800, "t6_timeout_status");
    bus_read(4'hB, 32'hFF, "t6_stat3");
    bus_read(4'h2, 32'h8, "t6_pend");
    bus_write(4'h2, 32'h8);
    bus_read(4'h1, 32'h0, "t6_timeout_cleared");
`else
    bus_read(4'h1, 32'h0000_0008, "t6_still_busy");
    bus_read(4'h2, 32'h0, "t6_no_pend");
    bus_read(4'hB, 32'h0, "t6_stat3");
`endif

    tick(2);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
